// File: rtl/product_accumulator_if.sv
// Handshake bundle between the multiplier stage, the product accumulator and
// the result consumer.
interface product_accumulator_if #(
  parameter int ACC_W = 16,
  parameter int LEN_W = 4
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       prod;
  logic             prod_ovf;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic             ovf_out;
  logic             busy;

  modport master (
    output start, len, in_valid, prod, prod_ovf, out_ready,
    input  in_ready, out_valid, acc_out, ovf_out, busy
  );

  modport slave (
    input  start, len, in_valid, prod, prod_ovf, out_ready,
    output in_ready, out_valid, acc_out, ovf_out, busy
  );
endinterface

// File: rtl/product_accumulator.sv
// Burst accumulator for signed 8-bit products with sticky overflow flag.
// Optional macro PRODUCT_ACC_SAT_EN: saturate instead of wrapping on overflow.
//
// state  | meaning
// IDLE   | waiting for start; last result still visible on acc_out/ovf_out
// ACC    | accepting len products
// DONE   | result presented until the consumer takes it
module product_accumulator #(
  parameter int ACC_W = 16,
  parameter int LEN_W = 4
) (
  input logic                   clk,
  input logic                   CLR,
  product_accumulator_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_e;

  state_e                  state_q, state_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [LEN_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    sticky_q, sticky_d;

  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum;
  logic                    add_ovf;
  logic signed [ACC_W-1:0] acc_upd;

  assign prod_ext = ACC_W'($signed(bus.prod));
  assign sum      = acc_q + prod_ext;
  assign add_ovf  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                    (sum[ACC_W-1] != acc_q[ACC_W-1]);

`ifdef PRODUCT_ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  // Overflow can only happen with same-sign addends, so acc_q's sign picks the rail.
  assign acc_upd = add_ovf ? (acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum;
`else
  assign acc_upd = sum;
`endif

  always_ff @(posedge clk) begin
    if (CLR) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    sticky_d      = sticky_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          len_d    = bus.len;
          cnt_d    = '0;
          acc_d    = '0;
          sticky_d = 1'b0;
          state_d  = (bus.len != '0) ? S_ACC : S_DONE;
        end
      end
      S_ACC: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b1;
        if (bus.in_valid) begin
          acc_d    = acc_upd;
          cnt_d    = cnt_q + 1'b1;
          sticky_d = sticky_q | bus.prod_ovf | add_ovf;
          if (cnt_q == len_q - 1'b1) state_d = S_DONE;
        end
      end
      S_DONE: begin
        bus.out_valid = 1'b1;
        bus.busy      = 1'b1;
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.acc_out = acc_q;
  assign bus.ovf_out = sticky_q;

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter ACC_W, default 16: accumulator and result width in bits; legal range 8..32.
REQ-002 Parameter LEN_W, default 4: width of the burst-length field.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 CLR  input  1  synchronous active-high reset.
REQ-006 start  input  1  request to begin a burst; sampled only in IDLE.
REQ-007 len  input  LEN_W  number of products in the burst, unsigned; latched on accepted start.
REQ-008 in_valid  input  1  prod/prod_ovf are valid this cycle.
REQ-009 in_ready  output  1  block accepts a product this cycle.
REQ-010 prod  input  8  two's-complement product from the 8-bit signed multiplier stage.
REQ-011 prod_ovf  input  1  multiplier overflow flag accompanying prod.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 acc_out  output  ACC_W  signed accumulated sum; driven directly from the accumulator register.
REQ-015 ovf_out  output  1  sticky overflow for the current/last burst.
REQ-016 busy  output  1  high in ACC and DONE.

Function
REQ-017 FSM states: IDLE, ACC, DONE; the FSM is the single source of in_ready, out_valid and busy, all registered-state decodes (no input-to-output combinational path).
REQ-018 IDLE: in_ready=0, out_valid=0; start=1 latches len, clears acc, count and sticky flag; next state ACC if len!=0, DONE if len==0.
REQ-019 ACC: in_ready=1; transfer occurs on in_valid&&in_ready at the clock edge.
REQ-020 On transfer: acc <= acc + sign_extend(prod, ACC_W); count <= count+1; sticky <= sticky | prod_ovf | add_ovf.
REQ-021 add_ovf: both addends same sign and sum sign differs.
REQ-022 Transfer with count==len-1 moves to DONE; out_valid rises the cycle after the last transfer.
REQ-023 in_valid low in ACC: no state change; cycles without transfer are unbounded.
REQ-024 DONE: out_valid=1, in_ready=0; acc_out and ovf_out held stable until out_valid&&out_ready, then next state IDLE.
REQ-025 start outside IDLE is ignored, including the cycle DONE hands off; a new start is accepted no earlier than the first IDLE cycle.
REQ-026 acc_out and ovf_out retain the last burst's values in IDLE until the next accepted start.
REQ-027 Maximum burst length 2^LEN_W-1; count width LEN_W, no wrap possible.

Reset
REQ-028 CLR=1 at a clock edge: state IDLE, acc=0, count=0, sticky=0, latched len=0; thus in_ready=0, out_valid=0, busy=0, acc_out=0, ovf_out=0.
REQ-029 CLR takes priority over start, transfer and output handshake; an in-flight product offered in the reset cycle is dropped.

Configuration
REQ-030 Macro PRODUCT_ACC_SAT_EN defined: on add_ovf the accumulator clamps to the signed maximum (positive overflow) or minimum (negative overflow); sticky still set.
REQ-031 PRODUCT_ACC_SAT_EN undefined: the accumulator wraps modulo 2^ACC_W; sticky still set.

Verification
REQ-032 CLR; start len=3; products 2, 35, -5 with prod_ovf=0 -> out_valid one cycle after third transfer, acc_out=32, ovf_out=0.
REQ-033 start len=0 -> DONE next cycle, out_valid=1, acc_out=0, ovf_out=0, no in_ready pulse.
REQ-034 len=2; products 10 (prod_ovf=0), 7 (prod_ovf=1) -> acc_out=17, ovf_out=1.
REQ-035 ACC_W=8, len=2, products 100, 100 -> ovf_out=1; acc_out=-56 without PRODUCT_ACC_SAT_EN, 127 with it.
REQ-036 DONE with out_ready=0 for 5 cycles, start=1 throughout -> out_valid, acc_out held, in_ready=0; out_ready=1 -> IDLE next cycle, start then accepted.
REQ-037 len=3, CLR after first transfer -> next cycle IDLE, acc_out=0, busy=0, in_ready=0.
